// File: rtl/mm_task_dispatcher.sv
// Task dispatcher for the matrix-multiply array: walks every (row, col) of the
// result matrix in row-major order, hands each one to the lowest free core with
// a one-cycle start pulse, counts completions, and raises end_process once the
// whole matrix has been computed.
module mm_task_dispatcher #(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned MAT_DIM   = 4,
  parameter int unsigned IDX_W     = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       begin_process,
  input  logic [NUM_CORES-1:0]       core_done,
  output logic [NUM_CORES-1:0]       core_start,
  output logic [NUM_CORES*IDX_W-1:0] core_row,
  output logic [NUM_CORES*IDX_W-1:0] core_col,
  output logic                       busy,
  output logic                       end_process
);

  localparam int unsigned CNT_W = 2 * IDX_W + 1;
  localparam logic [CNT_W-1:0] TOTAL    = CNT_W'(MAT_DIM * MAT_DIM);
  localparam logic [CNT_W-1:0] LAST_NUM = CNT_W'(MAT_DIM * MAT_DIM - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAT_DIM - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPATCH = 2'd1,
    DRAIN    = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [IDX_W-1:0]       next_row;
  logic [IDX_W-1:0]       next_col;
  logic [CNT_W-1:0]       issued;
  logic [CNT_W-1:0]       completed;
  logic [NUM_CORES-1:0]   core_busy;

  logic [NUM_CORES-1:0]   free_sel;
  logic [NUM_CORES-1:0]   issue_onehot;
  logic                   dispatch;
  logic [NUM_CORES-1:0]   done_valid;
  logic [CNT_W-1:0]       done_cnt;
  logic [CNT_W-1:0]       completed_nxt;

  // Pick the lowest-index idle core and count valid completions this cycle.
  always_comb begin
    free_sel = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (!core_busy[i]) free_sel = NUM_CORES'(1) << i;
    end
    dispatch     = (state == DISPATCH) && (free_sel != '0);
    issue_onehot = dispatch ? free_sel : '0;
    done_valid   = core_done & core_busy;
    done_cnt     = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      done_cnt = done_cnt + CNT_W'(done_valid[i]);
    end
    completed_nxt = completed + done_cnt;
  end

  // Next-state logic for the job sequencer.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (begin_process) state_nxt = DISPATCH;
      DISPATCH: if (dispatch && (issued == LAST_NUM)) state_nxt = DRAIN;
      DRAIN:    if (completed_nxt == TOTAL) state_nxt = DONE;
      DONE:     state_nxt = DONE;
      default:  state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Task issue, index walk, core bookkeeping and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      next_row    <= '0;
      next_col    <= '0;
      issued      <= '0;
      completed   <= '0;
      core_busy   <= '0;
      core_start  <= '0;
      core_row    <= '0;
      core_col    <= '0;
      busy        <= 1'b0;
      end_process <= 1'b0;
    end else begin
      core_start <= issue_onehot;
      for (int i = 0; i < NUM_CORES; i++) begin
        if (issue_onehot[i]) begin
          core_row[i*IDX_W +: IDX_W] <= next_row;
          core_col[i*IDX_W +: IDX_W] <= next_col;
        end
      end
      if (dispatch) begin
        issued <= issued + CNT_W'(1);
        if (next_col == LAST_IDX) begin
          next_col <= '0;
          next_row <= next_row + IDX_W'(1);
        end else begin
          next_col <= next_col + IDX_W'(1);
        end
      end
      // A core freed this edge only becomes selectable on the following edge.
      core_busy   <= (core_busy & ~done_valid) | issue_onehot;
      completed   <= completed_nxt;
      busy        <= (state_nxt == DISPATCH) || (state_nxt == DRAIN);
      end_process <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_mm_task_dispatcher.sv
// Directed bench for mm_task_dispatcher: a 2-core and a 4-core instance on 2x2
// matrices, with a start-pulse scoreboard and end_process/busy timing checks.
module tb_mm_task_dispatcher;

  localparam int unsigned IDX_W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              begin2, begin4;
  logic [1:0]        done2;
  logic [3:0]        done4;
  logic [1:0]        core_start2;
  logic [2*IDX_W-1:0] core_row2, core_col2;
  logic              busy2, end2;
  logic [3:0]        core_start4;
  logic [4*IDX_W-1:0] core_row4, core_col4;
  logic              busy4, end4;

  mm_task_dispatcher #(.NUM_CORES(2), .MAT_DIM(2), .IDX_W(IDX_W)) u_dut2 (
    .clock(clk), .reset(rst), .begin_process(begin2), .core_done(done2),
    .core_start(core_start2), .core_row(core_row2), .core_col(core_col2),
    .busy(busy2), .end_process(end2)
  );

  mm_task_dispatcher #(.NUM_CORES(4), .MAT_DIM(2), .IDX_W(IDX_W)) u_dut4 (
    .clock(clk), .reset(rst), .begin_process(begin4), .core_done(done4),
    .core_start(core_start4), .core_row(core_row4), .core_col(core_col4),
    .busy(busy4), .end_process(end4)
  );

  typedef struct packed {
    logic [7:0]  core;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [15:0] at_edge;
  } start_t;

  start_t q2[$];
  start_t q4[$];
  int vectors = 0;
  int miscompares = 0;
  int e = 0;
  int b = 0;
  int cnt2[2] = '{0, 0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic start_t mk(input int core, input int row, input int col, input int at);
    start_t s;
    s.core    = 8'(core);
    s.row     = 4'(row);
    s.col     = 4'(col);
    s.at_edge = 16'(at);
    return s;
  endfunction

  // Every start pulse must match the head of its scoreboard queue.
  task automatic check_starts();
    start_t got, exp;
    for (int i = 0; i < 2; i++) begin
      if (core_start2[i]) begin
        got = mk(i, int'(core_row2[i*IDX_W +: IDX_W]), int'(core_col2[i*IDX_W +: IDX_W]), e);
        exp = (q2.size() != 0) ? q2.pop_front() : '1;
        check("dut2_start", 32'(got), 32'(exp));
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (core_start4[i]) begin
        got = mk(i, int'(core_row4[i*IDX_W +: IDX_W]), int'(core_col4[i*IDX_W +: IDX_W]), e);
        exp = (q4.size() != 0) ? q4.pop_front() : '1;
        check("dut4_start", 32'(got), 32'(exp));
      end
    end
  endtask

  // Core model for the 2-core instance: done is sampled 3 edges after start.
  task automatic respond2();
    for (int i = 0; i < 2; i++) begin
      done2[i] = 1'b0;
      if (core_start2[i]) begin
        cnt2[i] = 2;
      end else if (cnt2[i] > 0) begin
        cnt2[i]--;
        if (cnt2[i] == 0) done2[i] = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    e++;
    check_starts();
    respond2();
  endtask

  initial begin
    rst = 1'b1; begin2 = 1'b0; begin4 = 1'b0; done2 = '0; done4 = '0;
    tick();
    check("rst_start2", 32'(core_start2), 32'd0);
    check("rst_rowcol2", 32'({core_row2, core_col2}), 32'd0);
    check("rst_flags2", 32'({busy2, end2}), 32'd0);
    check("rst_start4", 32'(core_start4), 32'd0);
    check("rst_rowcol4", 32'({core_row4, core_col4}), 32'd0);
    check("rst_flags4", 32'({busy4, end4}), 32'd0);
    tick();
    rst = 1'b0;

    // 2 cores, 2x2 matrix, each core completes 3 cycles after its start.
    b = e;
    q2.push_back(mk(0, 0, 0, b + 2));
    q2.push_back(mk(1, 0, 1, b + 3));
    q2.push_back(mk(0, 1, 0, b + 6));
    q2.push_back(mk(1, 1, 1, b + 7));
    begin2 = 1'b1;
    tick();
    begin2 = 1'b0;
    check("dut2_busy_after_begin", 32'(busy2), 32'd1);
    check("dut2_start_latency", 32'(core_start2), 32'd0);
    repeat (8) tick();
    check("dut2_end_before_last_done", 32'(end2), 32'd0);
    check("dut2_busy_before_last_done", 32'(busy2), 32'd1);
    tick();
    check("dut2_end_after_last_done", 32'(end2), 32'd1);
    check("dut2_busy_after_last_done", 32'(busy2), 32'd0);
    check("dut2_queue_drained", 32'(q2.size()), 32'd0);

    // begin_process held high in DONE is ignored.
    begin2 = 1'b1;
    repeat (4) tick();
    check("dut2_done_sticky", 32'({busy2, end2}), 32'd1);
    begin2 = 1'b0;

    // 4 cores, no completions: four starts then silence in DRAIN.
    b = e;
    q4.push_back(mk(0, 0, 0, b + 2));
    q4.push_back(mk(1, 0, 1, b + 3));
    q4.push_back(mk(2, 1, 0, b + 4));
    q4.push_back(mk(3, 1, 1, b + 5));
    begin4 = 1'b1;
    tick();
    begin4 = 1'b0;
    check("dut4_busy_after_begin", 32'(busy4), 32'd1);
    repeat (7) tick();
    check("dut4_queue_drained", 32'(q4.size()), 32'd0);
    check("dut4_drain_flags", 32'({busy4, end4}), 32'd2);

    // Complete cores 1 and 3, then a spurious done on idle core 3.
    done4 = 4'b1010;
    tick();
    done4 = 4'b0000;
    check("dut4_after_two_done", 32'({busy4, end4}), 32'd2);
    done4 = 4'b1000;
    tick();
    done4 = 4'b0000;
    check("dut4_after_spurious", 32'({busy4, end4}), 32'd2);
    // Cores 0 and 2 together, plus another spurious pulse on core 3.
    done4 = 4'b1101;
    tick();
    done4 = 4'b0000;
    check("dut4_end_after_pair", 32'(end4), 32'd1);
    check("dut4_busy_after_pair", 32'(busy4), 32'd0);

    // Reset clears the sticky DONE.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("end_cleared_by_reset", 32'({end2, end4}), 32'd0);

    // Asynchronous reset in the middle of dispatch.
    b = e;
    q4.push_back(mk(0, 0, 0, b + 2));
    q4.push_back(mk(1, 0, 1, b + 3));
    q4.push_back(mk(2, 1, 0, b + 4));
    q4.push_back(mk(3, 1, 1, b + 5));
    begin4 = 1'b1;
    tick();
    begin4 = 1'b0;
    tick();
    tick();
    check("dut4_col_before_reset", 32'(core_col4), 32'h0010);
    #2 rst = 1'b1;
    #1;
    check("async_rst_start", 32'(core_start4), 32'd0);
    check("async_rst_rowcol", 32'({core_row4, core_col4}), 32'd0);
    check("async_rst_flags", 32'({busy4, end4}), 32'd0);
    q4.delete();
    tick();
    rst = 1'b0;

    // Fresh job restarts from (0,0) on core 0.
    b = e;
    q4.push_back(mk(0, 0, 0, b + 2));
    q4.push_back(mk(1, 0, 1, b + 3));
    q4.push_back(mk(2, 1, 0, b + 4));
    q4.push_back(mk(3, 1, 1, b + 5));
    begin4 = 1'b1;
    tick();
    begin4 = 1'b0;
    repeat (4) tick();
    check("dut4_restart_drained", 32'(q4.size()), 32'd0);
    done4 = 4'b1111;
    tick();
    done4 = 4'b0000;
    check("dut4_restart_end", 32'({busy4, end4}), 32'd1);
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mm_task_dispatcher.md
Name: mm_task_dispatcher

Overview:
- Upstream stage of the main controller; produces the `end_process` signal that the controller consumes.
- On `begin_process`, walks all output elements of a MAT_DIM x MAT_DIM result matrix in row-major order and hands each (row, col) task to a free core with a one-cycle start pulse.
- Counts core completions and raises `end_process` once every element is done.

Parameters:
- NUM_CORES, 4, number of multiply cores served.
- MAT_DIM, 4, result matrix dimension (2..2^IDX_W).
- IDX_W, 4, width of row/col indices.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- begin_process  in  1  level; a job starts when sampled high in IDLE.
- core_done  in  NUM_CORES  per-core one-cycle completion pulse.
- core_start  out  NUM_CORES  per-core one-cycle task-start pulse.
- core_row  out  NUM_CORES*IDX_W  row index per core; core i at bits [i*IDX_W +: IDX_W].
- core_col  out  NUM_CORES*IDX_W  column index per core, same packing as core_row.
- busy  out  1  high in DISPATCH and DRAIN.
- end_process  out  1  high in DONE; feeds the main controller.

Behaviour:
- Reset (asynchronous, any time, including mid-job):
  - state = IDLE; all outputs 0.
  - next_row/next_col = 0; issued and completed counters = 0; per-core busy flags = 0.
  - Outstanding tasks are forgotten.
- All outputs are registered.
- FSM states:
  - IDLE -> DISPATCH when begin_process = 1 at an edge.
  - DISPATCH -> DRAIN on the edge that issues element MAT_DIM*MAT_DIM-1.
  - DRAIN -> DONE on the edge where the completed count reaches MAT_DIM*MAT_DIM.
  - DONE is sticky until reset; begin_process is ignored in DISPATCH, DRAIN and DONE.
- Dispatch:
  - In DISPATCH, at most one task is issued per clock.
  - Target is the lowest-index core whose busy flag is 0.
  - At that edge: core_start[i] <= 1, core_row/core_col slice i <= (next_row, next_col), busy flag i <= 1, issued count +1.
  - next_col increments; when it wraps from MAT_DIM-1 to 0, next_row increments.
  - core_start is a 1-cycle pulse (cleared on the next edge unless that core is dispatched again).
  - core_row/core_col slices hold their value until that core's next dispatch.
- Latency:
  - begin_process sampled at edge k -> DISPATCH from edge k.
  - First core_start is visible after edge k+1.
- Completion:
  - core_done[i] sampled with busy flag i = 1: clear flag i, completed count +1.
  - Multiple core_done bits in the same cycle are all counted (popcount).
  - core_done on a core whose busy flag is 0 is ignored and not counted.
  - A core freed at edge t is eligible for dispatch at edge t+1 (no same-edge reuse).
- Full condition: all busy flags set -> no issue that cycle; the index does not advance.
- end_process: asserted at the edge the completed count hits the total (enters DONE) and held.
- Widths:
  - Issued and completed counters are 2*IDX_W+1 bits.
  - Total = MAT_DIM*MAT_DIM, computed at elaboration.

Test Plan:
- MAT_DIM=2, NUM_CORES=2; reset, begin_process pulse, each core pulses core_done 3 cycles after its start -> starts in order (0,0)->core0, (0,1)->core1, (1,0)->core0, (1,1)->core1; end_process rises 1 edge after the 4th done; busy drops the same edge.
- NUM_CORES=4, MAT_DIM=2, no core_done -> 4 consecutive starts on cores 0..3; state DRAIN; no further starts; end_process stays 0.
- Simultaneous core_done on cores 0 and 2 in DRAIN with 2 outstanding -> completed +2 in one edge; end_process = 1 next cycle.
- Spurious core_done[3] while core 3 idle -> count unchanged; end_process timing unaffected.
- Reset asserted mid-DISPATCH (asynchronously, between edges) -> outputs 0 immediately; a new begin_process restarts from (0,0).
- begin_process held high through DONE -> no new starts; end_process stays 1 until reset.
